// File: rtl/ro_freq_counter.sv
// Ring-oscillator frequency counter: counts synchronised rising edges of osc_in
// over a programmable window of clk cycles and reports a saturating result.
module ro_freq_counter #(
  parameter int WINDOW_W    = 16,
  parameter int COUNT_W     = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [WINDOW_W-1:0] window,
  input  logic                osc_in,
  output logic                busy,
  output logic                done,
  output logic [COUNT_W-1:0]  count,
  output logic                overflow
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_COUNT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  localparam logic [WINDOW_W-1:0] WIN_ONE  = {{(WINDOW_W-1){1'b0}}, 1'b1};
  localparam logic [WINDOW_W-1:0] WIN_ZERO = {WINDOW_W{1'b0}};
  localparam logic [COUNT_W-1:0]  ACC_ONE  = {{(COUNT_W-1){1'b0}}, 1'b1};
  localparam logic [COUNT_W-1:0]  ACC_MAX  = {COUNT_W{1'b1}};
  localparam logic [COUNT_W-1:0]  ACC_ZERO = {COUNT_W{1'b0}};

  logic [SYNC_STAGES-1:0] sync_chain;
  logic                   hist;
  logic                   osc_edge;

  logic [1:0]          state;
  logic [1:0]          state_next;
  logic [WINDOW_W-1:0] win_cnt;
  logic [WINDOW_W-1:0] win_cnt_next;
  logic [COUNT_W-1:0]  acc;
  logic [COUNT_W-1:0]  acc_next;
  logic                sat;
  logic                sat_next;

  // Synchroniser and edge history run in every state so the first window cycle sees a valid edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_chain <= {SYNC_STAGES{1'b0}};
      hist       <= 1'b0;
    end else begin
      sync_chain <= {sync_chain[SYNC_STAGES-2:0], osc_in};
      hist       <= sync_chain[SYNC_STAGES-1];
    end
  end

  assign osc_edge = sync_chain[SYNC_STAGES-1] & ~hist;

  // Next-state, window down-counter and saturating accumulator.
  always_comb begin
    state_next   = state;
    win_cnt_next = win_cnt;
    acc_next     = acc;
    sat_next     = sat;
    case (state)
      ST_IDLE: begin
        if (start) begin
          win_cnt_next = window;
          acc_next     = ACC_ZERO;
          sat_next     = 1'b0;
          if (window == WIN_ZERO) begin
            state_next = ST_DONE;
          end else begin
            state_next = ST_COUNT;
          end
        end else begin
          state_next = ST_IDLE;
        end
      end
      ST_COUNT: begin
        win_cnt_next = win_cnt - WIN_ONE;
        // Saturate rather than wrap; an edge lost at the ceiling is flagged.
        if (osc_edge) begin
          if (acc == ACC_MAX) begin
            sat_next = 1'b1;
          end else begin
            acc_next = acc + ACC_ONE;
          end
        end else begin
          acc_next = acc;
        end
        if (win_cnt == WIN_ONE) begin
          state_next = ST_DONE;
        end else begin
          state_next = ST_COUNT;
        end
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // State and registered outputs; count/overflow are loaded as DONE is entered so they are valid with done.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      win_cnt  <= WIN_ZERO;
      acc      <= ACC_ZERO;
      sat      <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      count    <= ACC_ZERO;
      overflow <= 1'b0;
    end else begin
      state   <= state_next;
      win_cnt <= win_cnt_next;
      acc     <= acc_next;
      sat     <= sat_next;
      busy    <= (state_next == ST_COUNT);
      done    <= (state_next == ST_DONE);
      if (state_next == ST_DONE) begin
        count    <= acc_next;
        overflow <= sat_next;
      end else begin
        count    <= count;
        overflow <= overflow;
      end
    end
  end

endmodule

// File: tb/tb_ro_freq_counter.sv
// Directed bench for ro_freq_counter: a default instance and a COUNT_W=4 instance
// share stimulus; expected results are queued at start and checked at done.
module tb_ro_freq_counter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        osc_in = 1'b0;
  logic [15:0] window = 16'd0;

  logic        busy, done, overflow;
  logic [15:0] count;
  logic        busy4, done4, overflow4;
  logic [3:0]  count4;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [15:0] c;
    logic        o;
    logic [3:0]  c4;
    logic        o4;
  } exp_t;

  exp_t sb[$];

  int   osc_p = 4;
  int   osc_off = 0;
  logic osc_const = 1'b0;
  int   ph = 0;

  ro_freq_counter dut (
    .clk(clk), .rst(rst), .start(start), .window(window), .osc_in(osc_in),
    .busy(busy), .done(done), .count(count), .overflow(overflow)
  );

  ro_freq_counter #(.COUNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .start(start), .window(window), .osc_in(osc_in),
    .busy(busy4), .done(done4), .count(count4), .overflow(overflow4)
  );

  always #5 clk = ~clk;

  // Oscillator model: changes on the falling edge, period osc_p clk cycles, or constant when osc_p==0.
  initial begin
    forever begin
      @(negedge clk);
      ph = ph + 1;
      if (osc_p == 0) osc_in = osc_const;
      else osc_in = (((ph + osc_off) % osc_p) < (osc_p / 2));
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      chk("idle_busy", busy, 0);
      chk("idle_done", done, 0);
      cyc();
    end
  endtask

  task automatic push_exp(input int n);
    exp_t e;
    e.c  = n[15:0];
    e.o  = 1'b0;
    e.c4 = (n > 15) ? 4'd15 : n[3:0];
    e.o4 = (n > 15);
    sb.push_back(e);
  endtask

  // Drive start for exactly one accepting edge; afterwards scramble window to prove it was captured.
  task automatic launch(input int w, input int n, input bit push);
    @(negedge clk);
    window = w[15:0];
    start  = 1'b1;
    if (push) push_exp(n);
    @(posedge clk);
    #1;
    start  = 1'b0;
    window = 16'($urandom);
  endtask

  // Called #1 after the accepting edge (j=0); done must appear exactly at j==w.
  task automatic await_done(input int w, input int j0, input int s1, input int s2);
    bit   seen;
    int   j;
    exp_t e;
    seen = 1'b0;
    j    = j0;
    while (!seen && j <= w + 5) begin
      if (done) begin
        seen = 1'b1;
        chk("done_time", j, w);
        chk("done4", done4, 1);
        chk("busy_in_done", busy, 0);
        chk("sb_size", sb.size(), 1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          chk("count", count, e.c);
          chk("overflow", overflow, e.o);
          chk("count4", count4, e.c4);
          chk("overflow4", overflow4, e.o4);
        end
      end else begin
        chk("busy", busy, (j < w));
        start = (j == s1) || (j == s2);
        cyc();
        j++;
      end
    end
    start = 1'b0;
    chk("done_seen", seen, 1);
  endtask

  initial begin
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_count", count, 0);
      chk("rst_overflow", overflow, 0);
      cyc();
    end

    // Period 4 at four phase offsets: always 25 edges in 100 cycles.
    for (int off = 0; off < 4; off++) begin
      osc_p   = 4;
      osc_off = off;
      idle(5);
      launch(100, 25, 1'b1);
      await_done(100, 0, -1, -1);
      cyc();
      idle(2);
    end

    // Period 2: 20 edges; the 4-bit instance saturates.
    osc_p = 2;
    idle(5);
    launch(40, 20, 1'b1);
    await_done(40, 0, -1, -1);
    cyc();
    idle(2);

    // Zero window completes on the next cycle with a zero result.
    launch(0, 0, 1'b1);
    await_done(0, 0, -1, -1);
    cyc();
    idle(2);

    // Constant-high oscillator yields no edges.
    osc_p     = 0;
    osc_const = 1'b1;
    idle(5);
    launch(50, 0, 1'b1);
    await_done(50, 0, -1, -1);
    cyc();
    idle(2);

    // Extra start pulses during COUNT are ignored.
    osc_p = 4;
    idle(5);
    launch(100, 25, 1'b1);
    await_done(100, 0, 5, 60);
    cyc();
    idle(3);

    // start on the DONE cycle is ignored; held into the next cycle it is accepted.
    launch(20, 5, 1'b1);
    await_done(20, 0, -1, -1);
    start  = 1'b1;
    window = 16'd20;
    cyc();
    chk("done_start_busy", busy, 0);
    chk("done_start_done", done, 0);
    push_exp(5);
    cyc();
    start  = 1'b0;
    window = 16'($urandom);
    await_done(20, 0, -1, -1);
    cyc();
    idle(3);

    // Reset mid-COUNT aborts with no done pulse, then a fresh run works.
    launch(100, 0, 1'b0);
    for (int i = 0; i < 50; i++) cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_count", count, 0);
    chk("abort_overflow", overflow, 0);
    chk("abort_count4", count4, 0);
    idle(120);
    launch(100, 25, 1'b1);
    await_done(100, 0, -1, -1);
    cyc();
    idle(2);

    chk("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ro_freq_counter.md
Name: ro_freq_counter

Overview:
- Reads the free-running output of an inverter-chain ring oscillator and measures its frequency. The oscillator output is treated as asynchronous to clk.
- Counts the oscillator's rising edges over a programmable window of clk cycles, then presents the result with a done pulse.
- Sits between the oscillator macro and the tile I/O or scan logic, so each tapeout can characterise its own inverter delay.

Parameters:
- WINDOW_W, 16, width of the measurement-window length input (window in clk cycles).
- COUNT_W, 16, width of the edge-count result.
- SYNC_STAGES, 2, flip-flop depth of the osc_in synchroniser (minimum 2).

Ports:
- clk  input  1  system clock; all state on its rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a measurement; sampled only in IDLE.
- window  input  WINDOW_W  measurement length in clk cycles; captured when start is accepted.
- osc_in  input  1  ring-oscillator output, asynchronous to clk.
- busy  output  1  high while a measurement is in progress.
- done  output  1  one-cycle pulse when count/overflow are updated.
- count  output  COUNT_W  rising-edge count of the last completed measurement.
- overflow  output  1  last measurement saturated at 2^COUNT_W-1.

Behaviour:
- Reset: one clock; reset is synchronous and active-high (clk, rst).
  - On rst=1 at a clk edge: state=IDLE; busy=0, done=0, count=0, overflow=0.
  - Synchroniser flops, edge history, window counter and accumulator are all cleared.
  - rst during COUNT aborts the measurement; no done pulse is produced for it.
- Synchroniser: osc_in passes through a SYNC_STAGES flop chain and then one history flop.
  - edge = sync_out & ~hist.
  - The synchroniser and edge detector run continuously in every state, so edge history is valid on the first window cycle.
- States: IDLE, COUNT, DONE.
- IDLE:
  - Outputs: busy=0, done=0.
  - If start=1 at cycle t: capture window into a down-counter, clear the accumulator and the internal saturation flag.
  - If window!=0, go to COUNT; if window==0, go directly to DONE.
- COUNT:
  - Outputs: busy=1.
  - Counts the edge pulses seen in cycles t+1 through t+W inclusive (W = captured window).
  - The down-counter decrements each cycle; on the cycle it reaches 1, go to DONE.
  - Accumulator increments on edge and saturates at 2^COUNT_W-1. An edge arriving while saturated sets the sat flag; the accumulator does not wrap.
- DONE (single cycle, at t+W+1; t+1 when W=0):
  - count <= accumulator; overflow <= sat flag; done=1, busy=0; next state IDLE.
  - start is not accepted in DONE. The earliest next accept is the following cycle.
- start while busy or in DONE: ignored, no queuing. The captured window is unaffected by later changes on the window input.
- count and overflow hold their values until the next DONE or rst. busy and done are registered outputs.
- Oscillator frequency must be below clk/2 for exact counts. Faster input aliases; no detection is required.

Test Plan:
- Reset, then idle 10 cycles with osc_in toggling -> busy=0, done=0, count=0, overflow=0 throughout.
- osc_in period 4 clk (2 high, 2 low), start with window=100 -> busy high for 100 cycles; done pulses exactly 101 cycles after start; count=25, overflow=0. Repeat with 4 different phase offsets -> always 25.
- osc_in period 2 clk, window=40 -> count=20. With COUNT_W=4 override, same stimulus -> count=15, overflow=1.
- window=0 -> done one cycle after start; count=0. osc_in held constant 1, window=50 -> count=0.
- start pulsed again at cycles +5 and +60 during a window=100 run -> single done at +101; result unchanged (25 with period-4 osc). start asserted on the DONE cycle -> ignored; start on the next cycle -> accepted.
- rst asserted mid-COUNT (cycle +50 of window=100) -> next cycle busy=0, count=0, overflow=0; no done pulse ever for the aborted run. A fresh start afterwards yields 25.
